// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared constants and FSM state type for the keyboard scan controller
package kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] ASC_NONE = 8'h00;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_POP  = 1'b1
  } state_t;

endpackage

// File: rtl/kbd_ascii_rom.sv
// rtl/kbd_ascii_rom.sv - combinational PS/2 set-2 scan code to ASCII lookup
module kbd_ascii_rom
  import kbd_pkg::*;
(
  input  logic [7:0] scan_code,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASC_NONE;
    case (scan_code)
      8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
      // main-row digits, not the keypad
      8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      default: ascii = ASC_NONE;
    endcase
  end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// rtl/kbd_scan_ctrl.sv - pops the PS/2 byte FIFO and decodes make/break/extended sequences
module kbd_scan_ctrl
  import kbd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       kb_nextdata_n,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic [7:0] key_ascii,
  output logic [7:0] press_cnt,
  output logic       ovf_sticky
);

  state_t     state;
  logic [7:0] byte_r;
  logic       ext_pend;
  logic       brk_pend;
  logic [7:0] rom_ascii;
  logic       same_key;

  kbd_ascii_rom u_rom (
    .scan_code (byte_r),
    .ascii     (rom_ascii)
  );

  // Gated by rst so a reset landing in S_POP leaves the byte in the FIFO.
  assign kb_nextdata_n = !((state == S_POP) && !rst);

  assign same_key = key_valid && (byte_r == key_code) && (ext_pend == key_ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_r     <= 8'h00;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      key_valid  <= 1'b0;
      key_code   <= 8'h00;
      key_ext    <= 1'b0;
      key_ascii  <= ASC_NONE;
      press_cnt  <= 8'h00;
      ovf_sticky <= 1'b0;
    end else begin
      if (kb_overflow)
        ovf_sticky <= 1'b1;
      case (state)
        S_IDLE: begin
          if (kb_ready) begin
            byte_r <= kb_data;
            state  <= S_POP;
          end
        end
        S_POP: begin
          state <= S_IDLE;
          if (byte_r == SC_EXT) begin
            ext_pend <= 1'b1;
          end else if (byte_r == SC_BRK) begin
            brk_pend <= 1'b1;
          end else if (brk_pend) begin
            if (same_key)
              key_valid <= 1'b0;
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
          end else begin
            // A matching make while held is typematic repeat, not a new press.
            if (!same_key) begin
              key_valid <= 1'b1;
              key_code  <= byte_r;
              key_ext   <= ext_pend;
              key_ascii <= ext_pend ? ASC_NONE : rom_ascii;
              press_cnt <= press_cnt + 8'd1;
            end
            ext_pend <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// tb/tb_kbd_scan_ctrl.sv - directed self-checking bench for kbd_scan_ctrl
module tb_kbd_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_overflow;
  logic       kb_nextdata_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic [7:0] key_ascii;
  logic [7:0] press_cnt;
  logic       ovf_sticky;

  int tests = 0;
  int fails = 0;
  int pops = 0;
  int consec = 0;
  logic prev_nd = 1'b1;
  logic [7:0] fifo[$];

  kbd_scan_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .kb_data       (kb_data),
    .kb_ready      (kb_ready),
    .kb_overflow   (kb_overflow),
    .kb_nextdata_n (kb_nextdata_n),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_ext       (key_ext),
    .key_ascii     (key_ascii),
    .press_cnt     (press_cnt),
    .ovf_sticky    (ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of the FIFO model: present head at negedge, pop on a strobed posedge.
  task automatic cycle();
    logic nd;
    @(negedge clk);
    nd = kb_nextdata_n;
    if (!nd) pops++;
    if (!nd && !prev_nd) consec++;
    prev_nd = nd;
    kb_ready = (fifo.size() > 0);
    kb_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    @(posedge clk);
    if (!nd && fifo.size() > 0) void'(fifo.pop_front());
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (fifo.size() > 0 && n < 4000) begin
      cycle();
      n++;
    end
    check({tag, "_drain_timeout"}, 8'(fifo.size()), 8'h00);
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    fifo.push_back(a); fifo.push_back(b); fifo.push_back(c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo.delete();
    cycle(); cycle();
    rst = 1'b0;
    cycle();
  endtask

  initial begin
    rst = 1'b1; kb_data = 8'h00; kb_ready = 1'b0; kb_overflow = 1'b0;
    do_reset();
    check("rst_valid", 8'(key_valid), 8'h00);
    check("rst_code", key_code, 8'h00);
    check("rst_ext", 8'(key_ext), 8'h00);
    check("rst_ascii", key_ascii, 8'h00);
    check("rst_cnt", press_cnt, 8'h00);
    check("rst_ovf", 8'(ovf_sticky), 8'h00);
    check("rst_nd", 8'(kb_nextdata_n), 8'h01);

    fifo.push_back(8'h1C); drain("a_make");
    check("a_valid", 8'(key_valid), 8'h01);
    check("a_code", key_code, 8'h1C);
    check("a_ascii", key_ascii, 8'h61);
    check("a_cnt", press_cnt, 8'h01);
    fifo.push_back(8'hF0); fifo.push_back(8'h1C); drain("a_brk");
    check("a_rel_valid", 8'(key_valid), 8'h00);
    check("a_rel_code", key_code, 8'h1C);

    do_reset();
    push3(8'h1C, 8'h1C, 8'h1C); fifo.push_back(8'hF0); fifo.push_back(8'h1C);
    drain("rep");
    check("rep_cnt", press_cnt, 8'h01);
    check("rep_valid", 8'(key_valid), 8'h00);
    fifo.push_back(8'h45); drain("zero");
    check("zero_ascii", key_ascii, 8'h30);
    check("zero_cnt", press_cnt, 8'h02);

    do_reset();
    fifo.push_back(8'hE0); fifo.push_back(8'h75); drain("ext_make");
    check("ext_ext", 8'(key_ext), 8'h01);
    check("ext_code", key_code, 8'h75);
    check("ext_ascii", key_ascii, 8'h00);
    check("ext_cnt", press_cnt, 8'h01);
    check("ext_valid", 8'(key_valid), 8'h01);
    push3(8'hE0, 8'hF0, 8'h75); drain("ext_brk");
    check("ext_rel_valid", 8'(key_valid), 8'h00);
    fifo.push_back(8'h75); drain("plain75");
    check("p75_cnt", press_cnt, 8'h02);
    check("p75_ext", 8'(key_ext), 8'h00);
    check("p75_valid", 8'(key_valid), 8'h01);
    fifo.push_back(8'hF0); fifo.push_back(8'h1C); drain("wrong_rel");
    check("wrong_rel_valid", 8'(key_valid), 8'h01);
    push3(8'hE0, 8'hF0, 8'h75); drain("ext_rel_plain");
    check("extrel_plain_valid", 8'(key_valid), 8'h01);
    fifo.push_back(8'h29); drain("space");
    check("space_ascii", key_ascii, 8'h20);
    check("space_cnt", press_cnt, 8'h03);
    fifo.push_back(8'h5A); drain("enter");
    check("enter_ascii", key_ascii, 8'h0D);
    check("enter_code", key_code, 8'h5A);
    check("enter_cnt", press_cnt, 8'h04);
    push3(8'hF0, 8'hF0, 8'h5A); drain("dbl_brk");
    check("dbl_brk_valid", 8'(key_valid), 8'h00);

    do_reset();
    fifo.push_back(8'h1C);
    cycle();
    check("lat_nd_t1", 8'(kb_nextdata_n), 8'h00);
    check("lat_valid_t1", 8'(key_valid), 8'h00);
    cycle();
    check("lat_valid_t2", 8'(key_valid), 8'h01);
    check("lat_popped", 8'(fifo.size()), 8'h00);

    do_reset();
    pops = 0; consec = 0; prev_nd = 1'b1;
    push3(8'h15, 8'hF0, 8'h15);
    repeat (6) cycle();
    check("hs_fifo_empty", 8'(fifo.size()), 8'h00);
    repeat (10) cycle();
    check("hs_pops", 8'(pops), 8'h03);
    check("hs_consec", 8'(consec), 8'h00);
    check("hs_nd_idle", 8'(kb_nextdata_n), 8'h01);
    check("hs_valid", 8'(key_valid), 8'h00);

    do_reset();
    for (int i = 0; i < 255; i++) begin
      logic [7:0] c;
      c = 8'h10 + 8'(i % 16);
      push3(c, 8'hF0, c);
    end
    drain("wrap255");
    check("cnt_ff", press_cnt, 8'hFF);
    push3(8'h1A, 8'hF0, 8'h1A); drain("wrap256");
    check("cnt_wrap", press_cnt, 8'h00);
    check("wrap_valid", 8'(key_valid), 8'h00);

    check("ovf_before", 8'(ovf_sticky), 8'h00);
    kb_overflow = 1'b1;
    cycle();
    kb_overflow = 1'b0;
    repeat (5) cycle();
    check("ovf_sticky", 8'(ovf_sticky), 8'h01);
    fifo.push_back(8'h32); drain("ovf_decode");
    check("ovf_decode_ascii", key_ascii, 8'h62);
    do_reset();
    check("ovf_cleared", 8'(ovf_sticky), 8'h00);

    fifo.push_back(8'h1C);
    cycle();
    rst = 1'b1;
    #1;
    check("rstpop_nd", 8'(kb_nextdata_n), 8'h01);
    cycle();
    rst = 1'b0;
    check("rstpop_kept", 8'(fifo.size()), 8'h01);
    check("rstpop_valid", 8'(key_valid), 8'h00);
    drain("rstpop_reread");
    check("reread_valid", 8'(key_valid), 8'h01);
    check("reread_code", key_code, 8'h1C);
    check("reread_cnt", press_cnt, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kbd_scan_ctrl.md
# kbd_scan_ctrl

- Consumes the byte FIFO of `ps2_keyboard` and pops it with the `ready`/`nextdata_n` handshake.
- Decodes PS/2 set-2 make, break (`F0`) and extended (`E0`) prefixes.
- Tracks the currently held key and its ASCII value, and counts distinct key presses.
- Sits between `ps2_keyboard` and the seven-segment driver, which displays `key_code`, `key_ascii` and `press_cnt`.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `kb_data`  in  8  FIFO head byte from `ps2_keyboard`.
- `kb_ready`  in  1  FIFO non-empty; `kb_data` is valid.
- `kb_overflow`  in  1  FIFO overflow flag from `ps2_keyboard`.
- `kb_nextdata_n`  out  1  active-low pop strobe to `ps2_keyboard`.
- `key_valid`  out  1  a key is currently held.
- `key_code`  out  8  last make scan code, without prefix.
- `key_ext`  out  1  last make code was `E0`-prefixed.
- `key_ascii`  out  8  ASCII of `key_code`; `00` if unmapped or extended.
- `press_cnt`  out  8  count of distinct presses, wraps.
- `ovf_sticky`  out  1  `kb_overflow` has been seen since reset.

## Operation
- FSM states:
  - `S_IDLE`: if `kb_ready`=1, capture `kb_data` into `byte_r` and go to `S_POP`; otherwise stay.
  - `S_POP`: `kb_nextdata_n`=0 for exactly this cycle, process `byte_r`, then return unconditionally to `S_IDLE`.
- `kb_nextdata_n` = 0 only in `S_POP` and only when `rst`=0; it is 1 in all other cycles.
- `kb_ready` is never sampled in `S_POP`.
- Byte processing in `S_POP`:
  - `E0`: set `ext_pend`; outputs unchanged.
  - `F0`: set `brk_pend`; outputs unchanged.
  - Any other byte `c` with `brk_pend`=1 (release):
    - if `key_valid`=1 and `c`==`key_code` and `ext_pend`==`key_ext`: clear `key_valid`; `key_code`/`key_ascii`/`key_ext` hold their values.
    - otherwise: ignore.
    - in both cases, clear `brk_pend` and `ext_pend`.
  - Any other byte `c` with `brk_pend`=0 (make):
    - if `key_valid`=1 and `c`==`key_code` and `ext_pend`==`key_ext`: auto-repeat; no change.
    - otherwise: set `key_valid`=1, `key_code`=`c`, `key_ext`=`ext_pend`, `key_ascii`=lookup(`c`) (forced to `00` if `ext_pend`=1), and `press_cnt` += 1 (modulo 256, so `FF`→`00`).
    - in both cases, clear `ext_pend`.
- A new make while another key is held replaces the held key and counts as a press.
- `F0 F0 c` is treated as a single release of `c` (the second `F0` only re-sets `brk_pend`).
- `ovf_sticky` is set in any cycle where `kb_overflow`=1 and is cleared only by `rst`. Decoding continues after overflow.
- ASCII lookup (set 2):
  - `a`–`z` → `61`–`7A`
  - main-row `0`–`9` → `30`–`39`
  - space `29` → `20`
  - enter `5A` → `0D`
  - everything else → `00`

## Timing
- Reset values: `key_valid`=0, `key_code`=`00`, `key_ext`=0, `key_ascii`=`00`, `press_cnt`=`00`, `ovf_sticky`=0, `kb_nextdata_n`=1.
- Reset also puts the FSM in `S_IDLE` and clears `ext_pend`, `brk_pend` and `byte_r`.
- Reset during `S_POP`: no pop is issued (`kb_nextdata_n`=1 that cycle), the byte remains in the FIFO, and it is re-read after reset.
- Latency: if `kb_ready` rises in cycle T:
  - `kb_nextdata_n`=0 in cycle T+1;
  - decoded outputs are registered at the end of T+1 and are visible in T+2.
- Throughput: one byte per 2 cycles; back-to-back FIFO bytes are popped with no extra gap.
- All outputs are registered except `kb_nextdata_n`, which is a combinational decode of the state and `rst`.

## Structure
- Package `kbd_pkg`:
  - constants `SC_EXT`=`8'hE0`, `SC_BRK`=`8'hF0`;
  - FSM state type `{S_IDLE, S_POP}`;
  - ASCII constants `ASC_NONE`=`8'h00`.
- Sub-module `kbd_ascii_rom`: purely combinational 8-bit scan code → 8-bit ASCII lookup, instantiated once.

## Test plan
- Reset → all outputs at their reset values. Then FIFO bytes `1C F0 1C`, where `1C` is the `A` key → after `1C`: `key_valid`=1, `key_code`=`1C`, `key_ascii`=`61`, `press_cnt`=`01`; after `F0 1C`: `key_valid`=0, `key_code` stays `1C`.
- Auto-repeat: `1C 1C 1C F0 1C` → `press_cnt`=`01`. Then `45`, the `0` key → `key_ascii`=`30`, `press_cnt`=`02`.
- Extended: `E0 75 E0 F0 75` → `key_ext`=1, `key_code`=`75`, `key_ascii`=`00`, `press_cnt`=1. After the last byte, `key_valid`=0. A following plain `75` → counts as a new press, `key_ext`=0.
- Handshake timing:
  - `kb_ready` held high with 3 queued bytes → `kb_nextdata_n` low in exactly 3 alternating cycles, and never low in consecutive cycles.
  - `kb_ready` low → `kb_nextdata_n` stays 1.
- Wrap and overflow:
  - 256 distinct make/break pairs from reset → `press_cnt`=`00`.
  - Pulse `kb_overflow` for 1 cycle → `ovf_sticky`=1 until `rst`.
  - Assert `rst` in the `S_POP` cycle → `kb_nextdata_n`=1 and the byte is re-read after reset.
